// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with PC register and 2-entry fetch queue (optional feature macro: IFETCH_MISALIGN_TRAP_EN)
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [5:0]  imem_a,
    input  logic [31:0] imem_rd,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_plus4
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_fault
`endif
);

    logic [31:0] pc;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;
    logic        halted;
    logic [31:0] load_pc;
    logic        enq;
    logic        deq;

`ifdef IFETCH_MISALIGN_TRAP_EN
    // A misaligned redirect latches a sticky fault that freezes fetching
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_fault <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            fetch_fault <= 1'b1;
        end
    end

    assign halted  = fetch_fault;
    assign load_pc = redirect_pc;
`else
    assign halted  = 1'b0;
    assign load_pc = redirect_pc & 32'hFFFF_FFFC;
`endif

    assign imem_a       = pc[7:2];
    assign out_valid    = (count != 2'd0) && !reset;
    assign out_instr    = q_instr[rd_ptr];
    assign out_pc       = q_pc[rd_ptr];
    assign out_pc_plus4 = q_pc[rd_ptr] + 32'd4;

    // Handshake and fetch decisions; a redirect always suppresses the fetch
    always_comb begin
        deq = out_valid && out_ready;
        enq = !redirect_valid && !halted && ((count != 2'd2) || deq);
    end

    // PC, queue pointers and occupancy; reset beats redirect beats fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else if (redirect_valid) begin
            pc     <= load_pc;
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (enq) begin
                pc     <= pc + 32'd4;
                wr_ptr <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, enq} - {1'b0, deq};
        end
    end

    // Queue storage written at the write pointer on each fetch
    always_ff @(posedge clk) begin
        if (!reset && enq) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_rd;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - directed table-driven bench for ifetch
module tb_ifetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;

    logic [31:0] ram [64];

    int tests = 0;
    int failed = 0;

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic        ca;
        logic [5:0]  ea;
    } vec_t;

    vec_t vq[$];

    ifetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_a        (imem_a),
        .imem_rd       (imem_rd),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_instr     (out_instr),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4)
    );

    always #5 clk = ~clk;

    assign imem_rd = ram[imem_a];

    function automatic logic [31:0] ram_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {8'hA5, b, 8'h5A, ~b};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rv, input logic [31:0] rpc, input logic rdy,
                       input logic ev, input logic [31:0] epc, input logic ca, input logic [5:0] ea);
        vec_t v;
        v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.ev = ev; v.epc = epc; v.ca = ca; v.ea = ea;
        vq.push_back(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        logic [31:0] exp_next;
        logic [5:0]  widx;

        for (int i = 0; i < 64; i++) ram[i] = ram_word(i);

        //   rst rv  rpc           rdy ev  epc           ca  ea
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 6'd0);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 6'd0);
        // reset release, streaming with ready held high
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 6'd0);
        add(0, 0, 32'h0,         1, 1, 32'h0,         1, 6'd1);
        add(0, 0, 32'h0,         1, 1, 32'h4,         1, 6'd2);
        add(0, 0, 32'h0,         1, 1, 32'h8,         1, 6'd3);
        // back-pressure: queue fills and fetch stalls
        add(1, 0, 32'h0,         0, 0, 32'h0,         0, 6'd0);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 6'd0);
        add(0, 0, 32'h0,         0, 1, 32'h0,         1, 6'd1);
        add(0, 0, 32'h0,         0, 1, 32'h0,         1, 6'd2);
        add(0, 0, 32'h0,         0, 1, 32'h0,         1, 6'd2);
        add(0, 0, 32'h0,         0, 1, 32'h0,         1, 6'd2);
        add(0, 0, 32'h0,         1, 1, 32'h0,         1, 6'd2);
        add(0, 0, 32'h0,         1, 1, 32'h4,         1, 6'd3);
        add(0, 0, 32'h0,         0, 1, 32'h8,         1, 6'd4);
        // redirect while holding 0x8,0xC
        add(0, 1, 32'h40,        0, 1, 32'h8,         1, 6'd4);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 6'd16);
        add(0, 0, 32'h0,         1, 1, 32'h40,        1, 6'd17);
        // redirect coincident with a handshake, to the top of imem
        add(0, 1, 32'hFC,        1, 1, 32'h44,        1, 6'd18);
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 6'd63);
        add(0, 0, 32'h0,         1, 1, 32'hFC,        1, 6'd0);
        add(0, 0, 32'h0,         1, 1, 32'h100,       1, 6'd1);
        // reset with a full queue
        add(0, 0, 32'h0,         0, 1, 32'h104,       1, 6'd2);
        add(1, 0, 32'h0,         0, 0, 32'h0,         1, 6'd3);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 6'd0);
        add(0, 0, 32'h0,         0, 1, 32'h0,         1, 6'd1);
        // misaligned redirect target is aligned down
        add(0, 1, 32'h42,        0, 1, 32'h0,         1, 6'd2);
        add(0, 0, 32'h0,         0, 0, 32'h0,         1, 6'd16);
        add(0, 0, 32'h0,         0, 1, 32'h40,        1, 6'd17);
        // 32-bit PC wrap
        add(0, 1, 32'hFFFF_FFFC, 1, 1, 32'h40,        1, 6'd18);
        add(0, 0, 32'h0,         1, 0, 32'h0,         1, 6'd63);
        add(0, 0, 32'h0,         1, 1, 32'hFFFF_FFFC, 1, 6'd0);
        add(0, 0, 32'h0,         1, 1, 32'h0,         1, 6'd1);

        foreach (vq[i]) begin
            @(negedge clk);
            reset          = vq[i].rst;
            redirect_valid = vq[i].rv;
            redirect_pc    = vq[i].rpc;
            out_ready      = vq[i].rdy;
            #1;
            chk("out_valid", i, {31'b0, out_valid}, {31'b0, vq[i].ev});
            if (vq[i].ca) chk("imem_a", i, {26'b0, imem_a}, {26'b0, vq[i].ea});
            if (vq[i].ev) begin
                widx = vq[i].epc[7:2];
                chk("out_pc", i, out_pc, vq[i].epc);
                chk("out_instr", i, out_instr, ram_word(int'(widx)));
                chk("out_pc_plus4", i, out_pc_plus4, vq[i].epc + 32'd4);
            end
        end

        // Hand sequence: toggling ready must deliver a strictly ordered stream
        @(negedge clk);
        reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        hs = 0;
        exp_next = 32'h0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 3) != 0;
            #1;
            if (out_valid && out_ready) begin
                chk("stream_pc", c, out_pc, exp_next);
                chk("stream_instr", c, out_instr, ram_word(int'(exp_next[7:2])));
                exp_next = exp_next + 32'd4;
                hs++;
            end
            @(negedge clk);
        end
        chk("stream_handshakes", 0, 32'(hs), 32'd26);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Port clk  in  1  single clock, rising-edge.
REQ-003 Port reset  in  1  synchronous, active-high reset.
REQ-004 Port imem_a  out  6  word address to instruction memory, equal to pc[7:2].
REQ-005 Port imem_rd  in  32  instruction word returned combinationally for imem_a.
REQ-006 Port redirect_valid  in  1  branch/jump redirect request.
REQ-007 Port redirect_pc  in  32  redirect target PC.
REQ-008 Port out_valid  out  1  fetch queue head holds a valid instruction.
REQ-009 Port out_ready  in  1  decode accepts head this cycle.
REQ-010 Port out_instr  out  32  head instruction word.
REQ-011 Port out_pc  out  32  PC of head instruction.
REQ-012 Port out_pc_plus4  out  32  out_pc + 4, modulo 2^32.

Function
REQ-013 The block SHALL hold a 32-bit PC register and a 2-entry FIFO of {pc, instr}, with count 0..2.
REQ-014 imem_a SHALL be pc[7:2], combinational from the PC register.
REQ-015 Enqueue SHALL occur at a clock edge when redirect_valid=0 and (count<2 or a dequeue occurs in the same cycle); the entry is {pc, imem_rd}, and pc advances to pc+4.
REQ-016 When no enqueue occurs, the PC SHALL hold its value; imem_a stays constant while the queue is full.
REQ-017 Dequeue SHALL occur when out_valid=1 and out_ready=1; FIFO order is strict.
REQ-018 out_valid SHALL equal (count!=0); out_instr, out_pc and out_pc_plus4 SHALL come from the head entry and are don't-care when out_valid=0.
REQ-019 Simultaneous enqueue and dequeue at count=2 SHALL keep count=2 with no loss and no duplication.
REQ-020 Enqueued data SHALL be visible at the head no earlier than the cycle after the enqueue edge, giving a latency of 1 cycle from fetch to out_valid when the queue is empty.
REQ-021 A redirect_valid=1 at edge N SHALL complete any handshake in that cycle, flush all remaining entries (count=0), load pc<=redirect_pc, and suppress the enqueue.
REQ-022 After a redirect, the first instruction from redirect_pc SHALL present out_valid=1 at cycle N+2.
REQ-023 A redirect SHALL take priority over enqueue in all cases, including when the queue is full.
REQ-024 The PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000; imem_a SHALL wrap modulo 64 words.
REQ-025 The block SHALL issue no read and perform no state change other than as specified above.

Reset
REQ-026 On reset=1 at a clock edge: pc<=RESET_PC, count<=0, FIFO pointers<=0, and the fault flag cleared.
REQ-027 While reset=1, out_valid SHALL be 0; reset SHALL override redirect, enqueue and dequeue.
REQ-028 Reset mid-stream SHALL discard all queued entries; the first fetch after release is from RESET_PC.

Configuration
REQ-029 Macro IFETCH_MISALIGN_TRAP_EN SHALL select the misalignment behaviour.
REQ-030 With IFETCH_MISALIGN_TRAP_EN defined: the block adds an output port fetch_fault (out, 1).
REQ-031 With IFETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 sets fetch_fault=1 (sticky until reset), flushes the queue, and stops all further enqueues.
REQ-032 With IFETCH_MISALIGN_TRAP_EN undefined: there is no fetch_fault port, and redirect_pc[1:0] is forced to 0 on load.

Verification
REQ-033 Reset then out_ready=1 held -> out_pc sequence 0x0,0x4,0x8 on consecutive cycles, with out_instr=RAM[0],RAM[1],RAM[2] and out_valid first high 1 cycle after reset release.
REQ-034 out_ready=0 for 5 cycles -> count saturates at 2, imem_a stays at 2, head stays pc 0x0; release -> 0x0,0x4,0x8 with no gap or repeat.
REQ-035 Redirect to 0x40 while the queue holds 0x8,0xC and out_ready=0 -> both flushed, out_valid=0 for 1 cycle, next head out_pc=0x40, out_instr=RAM[16], out_pc_plus4=0x44.
REQ-036 Redirect to 0xFC -> out_pc 0xFC then 0x100, with imem_a 63 then 0 (wrap).
REQ-037 Reset asserted with count=2 -> out_valid=0 next cycle; after release, out_pc=RESET_PC.
REQ-038 With IFETCH_MISALIGN_TRAP_EN defined, redirect to 0x42 -> fetch_fault=1, out_valid stays 0 until reset; with the macro undefined -> out_pc=0x40.
